knock_pattern_matcher: RTL and testbench
========================================

// Module: knock_pattern_matcher
// PURPOSE
//  Upstream stage of the safe unlock path. Consumes single-cycle debounced knock pulses.
//  Times the intervals between knocks against a programmed rhythm.
//  Asserts pattern_ok, which drives the enable of the electromagnet/unlock stage.
//  Counts failed attempts and enforces a timed lockout after repeated failures.
// PARAMETERS
//  TICK_DIV    50000  CLOCK_50 cycles per 1 ms timebase tick (use 10 in sim)
//  N_KNOCKS    4      knocks per pattern (N_KNOCKS-1 intervals), range 2..8
//  TOL_MS      100    +/- acceptance window per interval, in ms
//  MAX_FAILS   3      consecutive failures before lockout
//  LOCKOUT_MS  10000  lockout duration, in ms
// PORTS
//  CLOCK_50    in   1               system clock, 50 MHz
//  reset       in   1               asynchronous reset, active-high
//  knock_pulse in   1               one-cycle debounced knock strobe
//  arm         in   1               level; 0 forces IDLE
//  relock      in   1               one-cycle strobe; ends MATCH
//  pattern_ms  in   12*(N_KNOCKS-1) target intervals in ms; interval i at bits [12i+11:12i]
//  pattern_ok  out  1               high while in MATCH; feeds downstream enable
//  busy        out  1               high while in MEASURE
//  lockout     out  1               high while in LOCKOUT
//  fail_count  out  3               consecutive failed attempts
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; tick, interval and idx counters cleared.
//  - Timebase: free-running divider emits ms_tick every TICK_DIV cycles.
//    Interval counter (12 bit) increments on ms_tick and saturates at 4095.
//  - Window for interval i: lo = max(0, P[i]-TOL_MS), hi = P[i]+TOL_MS, computed at 13 bits (no wrap).
//  - FSM states: IDLE, WAIT_FIRST, MEASURE, MATCH, LOCKOUT.
//  - IDLE: when arm=1, go to WAIT_FIRST on the next clock.
//  - WAIT_FIRST: on knock, clear the interval counter and tick divider, set idx=0, go to MEASURE.
//  - MEASURE, on knock:
//    - If lo<=cnt<=hi: idx++ and clear cnt. If idx was N_KNOCKS-2, go to MATCH and clear fail_count.
//    - Otherwise: FAIL.
//  - MEASURE, no knock and cnt>hi: FAIL (timeout).
//  - Same cycle knock and timeout: the knock is evaluated first.
//  - FAIL: fail_count++ (saturates at 7).
//    - If the new count >= MAX_FAILS: go to LOCKOUT and load the lockout ms counter.
//    - Otherwise go to WAIT_FIRST.
//  - MATCH: pattern_ok=1 and knocks ignored. On relock, go to WAIT_FIRST.
//  - LOCKOUT: knocks ignored. After LOCKOUT_MS ticks, fail_count=0 and go to WAIT_FIRST.
//  - arm=0 in any state: go to IDLE next clock; fail_count is kept.
//    arm=0 beats relock and knock in the same cycle.
//  - Outputs are registered (state decode). pattern_ok rises 1 clock after the qualifying knock.
//  - pattern_ms is sampled live. Software must hold it stable while busy=1.
// CONFIGURATION
//  KNOCK_LEARN_EN defined:
//   - Adds input learn (1 bit) and output learn_done (1 bit, one-cycle strobe).
//   - learn=1 in WAIT_FIRST enters LEARN. The next N_KNOCKS knocks record N_KNOCKS-1 intervals
//     into internal regs, which replace pattern_ms. Then learn_done pulses and the FSM goes to WAIT_FIRST.
//   - If cnt saturates during LEARN, abort to WAIT_FIRST with no update.
//   - Reset clears the learned flag, so the FSM falls back to pattern_ms.
//  KNOCK_LEARN_EN undefined: no learn ports or LEARN state; pattern always comes from pattern_ms.
// TESTING (TICK_DIV=10, N_KNOCKS=4, TOL_MS=100, MAX_FAILS=3, LOCKOUT_MS=500, pattern 300/300/600 ms)
//  1. arm=1, knocks at t=0/300/600/1200 ms -> pattern_ok=1 one clock after the 4th knock;
//     relock -> pattern_ok=0 and state WAIT_FIRST.
//  2. Knocks at 0/150 ms -> FAIL, fail_count=1, pattern_ok stays 0.
//     Knocks at 0/300/600 then silence -> fail_count=2 at cnt=701.
//  3. Three consecutive fails -> lockout=1. Knocks during lockout ignored.
//     lockout=0 and fail_count=0 after 500 ms.
//  4. Boundary: intervals 200/400/700 (lo/hi edges) -> match. 199 or 401 -> fail.
//  5. arm=0 mid-MEASURE with a knock in the same cycle -> IDLE, busy=0, fail_count unchanged.
//     Async reset mid-MATCH -> pattern_ok=0 immediately.
//  6. KNOCK_LEARN_EN: learn, knocks at 0/100/200/500 -> learn_done pulse.
//     Replaying 0/100/200/500 -> pattern_ok=1. The old 300/300/600 pattern fails.

Source files
------------

// File: rtl/knock_pattern_matcher.sv
// Knock rhythm matcher: times knock intervals against a programmed pattern, raises pattern_ok
// on a match, locks out after repeated failures. Define KNOCK_LEARN_EN to add rhythm learning.
module knock_pattern_matcher #(
  parameter int TICK_DIV   = 50000,
  parameter int N_KNOCKS   = 4,
  parameter int TOL_MS     = 100,
  parameter int MAX_FAILS  = 3,
  parameter int LOCKOUT_MS = 10000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       knock_pulse,
  input  logic                       arm,
  input  logic                       relock,
  input  logic [12*(N_KNOCKS-1)-1:0] pattern_ms,
`ifdef KNOCK_LEARN_EN
  input  logic                       learn,
  output logic                       learn_done,
`endif
  output logic                       pattern_ok,
  output logic                       busy,
  output logic                       lockout,
  output logic [2:0]                 fail_count
);
  localparam int NI     = N_KNOCKS - 1;
  localparam int PW     = 12 * NI;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LOCK_W = $clog2(LOCKOUT_MS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCKOUT_MS);
  localparam logic [12:0]       TOL       = 13'(TOL_MS);
  localparam logic [2:0]        FAIL_MAX  = 3'(MAX_FAILS);
  localparam logic [2:0]        LAST_IDX  = 3'(NI - 1);
  localparam logic [11:0]       CNT_SAT   = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIRST = 3'd1,
    MEASURE    = 3'd2,
    MATCH      = 3'd3,
    LOCKOUT    = 3'd4
`ifdef KNOCK_LEARN_EN
    , LEARN    = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [11:0]         cnt_q;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          fail_q, fail_d, fail_inc;
  logic [LOCK_W-1:0]   lock_q;
  logic                ms_tick;
  logic                cnt_clr, div_clr, lock_load, do_fail;
  logic [PW-1:0]       pat_eff;
  logic [12:0]         p_cur, win_lo, win_hi, cnt_ext;
  logic                in_win, over;

`ifdef KNOCK_LEARN_EN
  logic                learned_q;
  logic [PW-1:0]       learned_pat_q, learn_buf_q, buf_next;
  logic [2:0]          lcnt_q, lcnt_d;
  logic                buf_wr, commit;
  localparam logic [2:0] LAST_SLOT = 3'(NI);

  assign pat_eff = learned_q ? learned_pat_q : pattern_ms;
`else
  assign pat_eff = pattern_ms;
`endif

  assign ms_tick  = (div_q == DIV_LAST);
  // Window bounds are 13 bits wide so hi never wraps and lo clamps at zero.
  assign p_cur    = {1'b0, pat_eff[12*int'(idx_q) +: 12]};
  assign win_lo   = (p_cur >= TOL) ? (p_cur - TOL) : 13'd0;
  assign win_hi   = p_cur + TOL;
  assign cnt_ext  = {1'b0, cnt_q};
  assign in_win   = (cnt_ext >= win_lo) && (cnt_ext <= win_hi);
  assign over     = (cnt_ext > win_hi);
  assign fail_inc = (fail_q == 3'd7) ? fail_q : (fail_q + 3'd1);
  assign fail_count = fail_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    cnt_clr   = 1'b0;
    div_clr   = 1'b0;
    lock_load = 1'b0;
    do_fail   = 1'b0;
`ifdef KNOCK_LEARN_EN
    lcnt_d    = lcnt_q;
    buf_wr    = 1'b0;
    commit    = 1'b0;
`endif
    case (state_q)
      IDLE: if (arm) state_d = WAIT_FIRST;
      WAIT_FIRST: begin
`ifdef KNOCK_LEARN_EN
        if (learn) begin
          state_d = LEARN;
          lcnt_d  = 3'd0;
        end else
`endif
        if (knock_pulse) begin
          cnt_clr = 1'b1;
          div_clr = 1'b1;
          idx_d   = 3'd0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // A knock is judged before the timeout of the same cycle.
        if (knock_pulse) begin
          if (in_win) begin
            cnt_clr = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = MATCH;
              fail_d  = 3'd0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            do_fail = 1'b1;
          end
        end else if (over) begin
          do_fail = 1'b1;
        end
      end
      MATCH: if (relock) state_d = WAIT_FIRST;
      LOCKOUT: begin
        if (ms_tick && (lock_q <= LOCK_W'(1))) begin
          fail_d  = 3'd0;
          state_d = WAIT_FIRST;
        end
      end
`ifdef KNOCK_LEARN_EN
      LEARN: begin
        if (knock_pulse) begin
          cnt_clr = 1'b1;
          if (lcnt_q == 3'd0) begin
            div_clr = 1'b1;
            lcnt_d  = 3'd1;
          end else begin
            buf_wr = 1'b1;
            lcnt_d = lcnt_q + 3'd1;
            if (lcnt_q == LAST_SLOT) begin
              commit  = 1'b1;
              lcnt_d  = 3'd0;
              state_d = WAIT_FIRST;
            end
          end
        end else if ((lcnt_q != 3'd0) && (cnt_q == CNT_SAT)) begin
          state_d = WAIT_FIRST;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (do_fail) begin
      fail_d = fail_inc;
      if (fail_inc >= FAIL_MAX) begin
        state_d   = LOCKOUT;
        lock_load = 1'b1;
      end else begin
        state_d = WAIT_FIRST;
      end
    end

    // Disarm overrides everything else in the same cycle and preserves the fail history.
    if (!arm) begin
      state_d   = IDLE;
      fail_d    = fail_q;
      lock_load = 1'b0;
`ifdef KNOCK_LEARN_EN
      buf_wr    = 1'b0;
      commit    = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      fail_q     <= '0;
      lock_q     <= '0;
      pattern_ok <= 1'b0;
      busy       <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      if (div_clr || ms_tick) div_q <= '0;
      else                    div_q <= div_q + DIV_W'(1);
      if (cnt_clr)                            cnt_q <= '0;
      else if (ms_tick && (cnt_q != CNT_SAT)) cnt_q <= cnt_q + 12'd1;
      if (lock_load) lock_q <= LOCK_INIT;
      else if ((state_q == LOCKOUT) && ms_tick && (lock_q != '0)) lock_q <= lock_q - LOCK_W'(1);
      pattern_ok <= (state_d == MATCH);
      busy       <= (state_d == MEASURE);
      lockout    <= (state_d == LOCKOUT);
    end
  end

`ifdef KNOCK_LEARN_EN
  always_comb begin
    buf_next = learn_buf_q;
    if (lcnt_q != 3'd0) buf_next[12*(int'(lcnt_q)-1) +: 12] = cnt_q;
  end

  // Intervals collect in a staging buffer; the active pattern changes only on a full capture.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      learned_q     <= 1'b0;
      learned_pat_q <= '0;
      learn_buf_q   <= '0;
      lcnt_q        <= '0;
      learn_done    <= 1'b0;
    end else begin
      lcnt_q     <= lcnt_d;
      learn_done <= commit;
      if (buf_wr) learn_buf_q <= buf_next;
      if (commit) begin
        learned_pat_q <= buf_next;
        learned_q     <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_knock_pattern_matcher.sv
// Self-checking bench for knock_pattern_matcher (TICK_DIV=10, pattern 300/300/600 ms).
// Knocks land mid-millisecond so every measured interval equals the nominal ms value.
module tb_knock_pattern_matcher;
  localparam int TICK_DIV   = 10;
  localparam int N_KNOCKS   = 4;
  localparam int TOL_MS     = 100;
  localparam int MAX_FAILS  = 3;
  localparam int LOCKOUT_MS = 500;
  localparam int W          = 6;

  logic        clk = 1'b0;
  logic        reset, knock_pulse, arm, relock;
  logic [35:0] pattern_ms;
  logic        pattern_ok, busy, lockout;
  logic [2:0]  fail_count;
`ifdef KNOCK_LEARN_EN
  logic        learn, learn_done;
`endif

  knock_pattern_matcher #(
    .TICK_DIV(TICK_DIV), .N_KNOCKS(N_KNOCKS), .TOL_MS(TOL_MS),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_MS(LOCKOUT_MS)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .knock_pulse(knock_pulse), .arm(arm), .relock(relock),
    .pattern_ms(pattern_ms),
`ifdef KNOCK_LEARN_EN
    .learn(learn), .learn_done(learn_done),
`endif
    .pattern_ok(pattern_ok), .busy(busy), .lockout(lockout), .fail_count(fail_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic ok, input logic bz, input logic lk, input int fc);
    return {ok, bz, lk, 3'(fc)};
  endfunction

  function automatic logic [W-1:0] outs();
    return {pattern_ok, busy, lockout, fail_count};
  endfunction

  task automatic expect_out(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe();
    string        t;
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'(1));
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, 32'(outs()), 32'(e));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic knock();
    knock_pulse = 1'b1;
    step(1);
    knock_pulse = 1'b0;
  endtask

  task automatic knock_after(input int ms, input int extra);
    step(TICK_DIV * ms + extra - 1);
    knock();
  endtask

  task automatic relock_pulse();
    relock = 1'b1;
    step(1);
    relock = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; knock_pulse = 1'b0; arm = 1'b0; relock = 1'b0;
    pattern_ms = {12'd600, 12'd300, 12'd300};
`ifdef KNOCK_LEARN_EN
    learn = 1'b0;
`endif
    step(3);
    expect_out("reset", mk(0, 0, 0, 0)); observe();
    reset = 1'b0;
    arm = 1'b1;
    step(1);
    expect_out("armed", mk(0, 0, 0, 0)); observe();

    // nominal match then relock
    expect_out("s1_first", mk(0, 1, 0, 0)); knock(); observe();
    knock_after(300, 5);
    knock_after(300, 0);
    expect_out("s1_pre_last", mk(0, 1, 0, 0)); observe();
    expect_out("s1_match", mk(1, 0, 0, 0)); knock_after(600, 0); observe();
    expect_out("s1_knock_ignored", mk(1, 0, 0, 0)); step(20); knock(); observe();
    expect_out("s1_relock", mk(0, 0, 0, 0)); relock_pulse(); observe();
    expect_out("s1_wait_first", mk(0, 1, 0, 0)); knock(); observe();

    // short interval, then timeout after the third knock
    expect_out("s2_short", mk(0, 0, 0, 1)); knock_after(150, 5); observe();
    expect_out("s2_restart", mk(0, 1, 0, 1)); knock(); observe();
    knock_after(300, 5);
    knock_after(300, 0);
    step(7000);
    expect_out("s2_cnt700", mk(0, 1, 0, 1)); observe();
    step(10);
    expect_out("s2_timeout", mk(0, 0, 0, 2)); observe();

    // third failure locks out; knocks ignored; lockout expires after 500 ms
    knock();
    expect_out("s3_lockout", mk(0, 0, 1, 3)); knock_after(150, 5); observe();
    step(99);
    expect_out("s3_knock_ignored", mk(0, 0, 1, 3)); knock(); observe();
    step(4800);
    expect_out("s3_still_locked", mk(0, 0, 1, 3)); observe();
    step(100);
    expect_out("s3_released", mk(0, 0, 0, 0)); observe();

    // window edges: 200/400/700 accepted, 199 rejected, 401 times out
    knock();
    knock_after(200, 5);
    knock_after(400, 0);
    expect_out("s4_edges_match", mk(1, 0, 0, 0)); knock_after(700, 0); observe();
    relock_pulse();
    knock();
    expect_out("s4_199", mk(0, 0, 0, 1)); knock_after(199, 5); observe();
    knock();
    knock_after(300, 5);
    step(4000);
    expect_out("s4_400_open", mk(0, 1, 0, 1)); observe();
    step(10);
    expect_out("s4_401", mk(0, 0, 0, 2)); observe();

    // disarm with a simultaneous knock keeps fail_count
    knock();
    step(100);
    arm = 1'b0; knock_pulse = 1'b1;
    step(1);
    knock_pulse = 1'b0;
    expect_out("s5_disarm", mk(0, 0, 0, 2)); observe();
    expect_out("s5_idle_knock", mk(0, 0, 0, 2)); knock(); observe();
    arm = 1'b1;
    step(1);
    knock();
    knock_after(300, 5);
    knock_after(300, 0);
    expect_out("s5_match", mk(1, 0, 0, 0)); knock_after(600, 0); observe();
    step(2);
    reset = 1'b1;
    #1;
    expect_out("s5_async_reset", mk(0, 0, 0, 0)); observe();
    #1 reset = 1'b0;
    step(1);

`ifdef KNOCK_LEARN_EN
    // learn 100/100/300, replay it, old pattern now fails
    learn = 1'b1;
    step(1);
    learn = 1'b0;
    knock();
    knock_after(100, 5);
    knock_after(100, 0);
    knock_after(300, 0);
    check("s6_learn_done", 32'(learn_done), 32'(1));
    step(1);
    check("s6_learn_done_pulse", 32'(learn_done), 32'(0));
    knock();
    knock_after(100, 5);
    knock_after(100, 0);
    expect_out("s6_replay", mk(1, 0, 0, 0)); knock_after(300, 0); observe();
    relock_pulse();
    knock();
    expect_out("s6_old_fails", mk(0, 1, 0, 1)); knock_after(300, 5); observe();
`endif

    check("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
